// File: rtl/gcd_seq_if.sv
// rtl/gcd_seq_if.sv - operand, result and core-side bus of the GCD sequencer
interface gcd_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic             core_start;
  logic [WIDTH-1:0] core_opa;
  logic [WIDTH-1:0] core_opb;
  logic [WIDTH-1:0] core_result;
  logic             core_done;

  // slave: the sequencer itself
  modport slave (
    input  in_valid, in_a, in_b, out_ready, core_result, core_done,
    output in_ready, out_valid, out_result, out_err, core_start, core_opa, core_opb
  );

  // master: the surrounding system (producer, consumer and core)
  modport master (
    output in_valid, in_a, in_b, out_ready, core_result, core_done,
    input  in_ready, out_valid, out_result, out_err, core_start, core_opa, core_opb
  );
endinterface

// File: rtl/gcd_seq.sv
// rtl/gcd_seq.sv - operand FIFO, GCD core sequencer and result collector
module gcd_seq #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  gcd_seq_if.slave    bus,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [TW-1:0] T_ONE   = 1;
  localparam logic [TW-1:0] T_ZERO  = '0;
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t             state_q, state_d;
  logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
  logic [2*WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic [TW-1:0]      timer_q, timer_d;

  logic               full, empty, push, pop;
  logic [WIDTH-1:0]   head_a, head_b;

  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push   = bus.in_valid && !full;
  assign pop    = (state_q == IDLE) && !empty;
  assign head_a = mem_q[rd_q[AW-1:0]][2*WIDTH-1:WIDTH];
  assign head_b = mem_q[rd_q[AW-1:0]][WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {bus.in_a, bus.in_b};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = push ? wr_q + PTR_ONE : wr_q;
    rd_d    = pop ? rd_q + PTR_ONE : rd_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          // A zero operand makes the answer the other operand; no core run needed.
          if (head_a == '0 || head_b == '0) begin
            res_d   = head_a | head_b;
            err_d   = 1'b0;
            state_d = OUT;
          end else begin
            opa_d   = head_a;
            opb_d   = head_b;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + T_ONE;
        // timer_q == 0 marks the first WAIT cycle, where done may still be stale.
        if (timer_q != T_ZERO && bus.core_done) begin
          res_d   = bus.core_result;
          err_d   = 1'b0;
          state_d = OUT;
        end else if (timer_q == T_MAX) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready   = !full;
  assign bus.out_valid  = (state_q == OUT);
  assign bus.out_result = res_q;
  assign bus.out_err    = err_q;
  assign bus.core_start = (state_q == ISSUE);
  assign bus.core_opa   = opa_q;
  assign bus.core_opb   = opb_q;
  assign busy           = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_gcd_seq.sv
// tb/tb_gcd_seq.sv - directed bench for gcd_seq with a behavioural core stub
module tb_gcd_seq;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  int   checks = 0;
  int   failures = 0;

  gcd_seq_if #(.WIDTH(32)) bus();

  gcd_seq #(.WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave), .busy(busy)
  );

  always #5 clk = ~clk;

  // core stub: mode 0 = done 4 cycles after start, 1 = never done, 2 = done stuck high
  int          mode = 0;
  logic        done_m = 1'b0;
  logic [31:0] result_m = '0;
  logic [31:0] pend_m = '0;
  int          cnt_m = 0;
  logic        start_prev = 1'b0;
  int          start_cnt = 0;
  logic [31:0] last_opa = '0;
  logic [31:0] last_opb = '0;

  assign bus.core_done   = done_m;
  assign bus.core_result = result_m;

  function automatic logic [31:0] gcd_f(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a, y = b, t;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  always @(posedge clk) begin
    start_prev <= bus.core_start;
    if (bus.core_start && !start_prev) begin
      start_cnt <= start_cnt + 1;
      last_opa  <= bus.core_opa;
      last_opb  <= bus.core_opb;
      pend_m    <= gcd_f(bus.core_opa, bus.core_opb);
      if (mode == 2) begin
        done_m   <= 1'b1;
        result_m <= gcd_f(bus.core_opa, bus.core_opb);
      end else begin
        done_m <= 1'b0;
        cnt_m  <= 4;
      end
    end else if (mode == 0 && cnt_m != 0) begin
      cnt_m <= cnt_m - 1;
      if (cnt_m == 1) begin
        done_m   <= 1'b1;
        result_m <= pend_m;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // called just after a negedge; leaves in_valid high, returns on the negedge after acceptance
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("send_timeout", 32'(n), 32'(0));
    @(negedge clk);
  endtask

  task automatic get_result(input string tag, input logic [31:0] exp, input logic exp_err);
    int n = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(1));
    check({tag, "_result"}, bus.out_result, exp);
    check({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
    @(negedge clk);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus.core_start && n < 200) begin @(negedge clk); n++; end
    check("wait_start", 32'(bus.core_start), 32'(1));
  endtask

  initial begin
    int s, k;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_result", bus.out_result, 32'(0));
    check("rst_out_err", 32'(bus.out_err), 32'(0));
    check("rst_core_start", 32'(bus.core_start), 32'(0));
    check("rst_core_opa", bus.core_opa, 32'(0));
    check("rst_core_opb", bus.core_opb, 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    resetn = 1'b1;
    @(negedge clk);

    // single core operation
    s = start_cnt;
    send(48, 18);
    bus.in_valid = 1'b0;
    get_result("g48_18", 6, 1'b0);
    check("g48_18_starts", 32'(start_cnt - s), 32'(1));
    check("g48_18_opa", last_opa, 32'(48));
    check("g48_18_opb", last_opb, 32'(18));
    check("g48_18_single_hs", 32'(bus.out_valid), 32'(0));

    // zero-operand bypass, including 2-cycle latency
    s = start_cnt;
    send(0, 35);
    bus.in_valid = 1'b0;
    check("byp_lat1_valid", 32'(bus.out_valid), 32'(0));
    check("byp_lat1_busy", 32'(busy), 32'(1));
    @(negedge clk);
    check("byp_lat2_valid", 32'(bus.out_valid), 32'(1));
    get_result("byp_0_35", 35, 1'b0);
    send(35, 0);
    bus.in_valid = 1'b0;
    get_result("byp_35_0", 35, 1'b0);
    send(0, 0);
    bus.in_valid = 1'b0;
    get_result("byp_0_0", 0, 1'b0);
    check("byp_no_start", 32'(start_cnt - s), 32'(0));

    // fill FIFO with out_ready low, hold in OUT, then drain in order
    bus.out_ready = 1'b0;
    send(12, 8);
    send(7, 13);
    send(100, 75);
    send(9, 27);
    send(0, 5);
    bus.in_a = 21;
    bus.in_b = 14;
    check("full_in_ready", 32'(bus.in_ready), 32'(0));
    k = 0;
    while (!bus.out_valid && k < 200) begin @(negedge clk); k++; end
    s = start_cnt;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(bus.out_valid), 32'(1));
      check("hold_result", bus.out_result, 32'(4));
      check("hold_err", 32'(bus.out_err), 32'(0));
      @(negedge clk);
    end
    check("hold_no_start", 32'(start_cnt - s), 32'(0));
    check("hold_in_ready", 32'(bus.in_ready), 32'(0));
    bus.out_ready = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 200) begin @(negedge clk); k++; end
    check("drain_in_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    get_result("q_7_13", 1, 1'b0);
    get_result("q_100_75", 25, 1'b0);
    get_result("q_9_27", 9, 1'b0);
    get_result("q_0_5", 5, 1'b0);
    get_result("q_21_14", 7, 1'b0);

    // core never finishes: timeout at ISSUE+17
    mode = 1;
    send(30, 12);
    bus.in_valid = 1'b0;
    wait_start();
    k = 0;
    while (!bus.out_valid && k < 100) begin @(negedge clk); k++; end
    check("tmo_latency", 32'(k), 32'(17));
    check("tmo_err", 32'(bus.out_err), 32'(1));
    check("tmo_result", bus.out_result, 32'(0));
    @(negedge clk);

    // stale done stuck high: first WAIT cycle ignored
    mode = 2;
    send(45, 30);
    bus.in_valid = 1'b0;
    wait_start();
    k = 0;
    while (!bus.out_valid && k < 100) begin @(negedge clk); k++; end
    check("stuck_latency", 32'(k), 32'(3));
    get_result("stuck_45_30", 15, 1'b0);

    // reset during WAIT with two pairs queued
    mode = 1;
    send(40, 16);
    send(20, 5);
    send(9, 3);
    bus.in_valid = 1'b0;
    check("mid_busy", 32'(busy), 32'(1));
    resetn = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("mid_rst_out_result", bus.out_result, 32'(0));
    check("mid_rst_out_err", 32'(bus.out_err), 32'(0));
    check("mid_rst_core_start", 32'(bus.core_start), 32'(0));
    check("mid_rst_core_opa", bus.core_opa, 32'(0));
    check("mid_rst_core_opb", bus.core_opb, 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    resetn = 1'b1;
    mode = 0;
    s = start_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(bus.out_valid), 32'(0));
    end
    check("post_rst_no_start", 32'(start_cnt - s), 32'(0));
    check("post_rst_busy", 32'(busy), 32'(0));
    send(14, 21);
    bus.in_valid = 1'b0;
    get_result("post_rst_14_21", 7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
